alu_vector_runner: RTL and testbench

Synthesizable stimulus-and-check engine for the 32-bit ALU (`ula`) and any later ALU revision with the same port set. It fetches 100-bit test vectors from a synchronous vector ROM and drives `a`, `b` and `controle` into the device under test (DUT). It then compares the DUT's `result`, `zero` and `overflow` against the expected fields and reports per-vector mismatches and a saturating error count. It is the driving and checking end of the ALU interface, so regression can run on silicon or FPGA without a simulator.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_vec_compare.sv | 20 ++
 rtl/alu_vector_runner.sv | 134 +++++++++++++
 tb/tb_alu_vector_runner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU vector runner: operation codes, vector field layout,
// terminator word and runner FSM states.
package alu_pkg;

  localparam logic [1:0] CtlAdd = 2'b00;
  localparam logic [1:0] CtlSub = 2'b01;
  localparam logic [1:0] CtlAnd = 2'b10;
  localparam logic [1:0] CtlOr  = 2'b11;

  localparam int unsigned VecW      = 100;
  localparam int unsigned ZeroExpB  = 99;
  localparam int unsigned OvfExpB   = 98;
  localparam int unsigned CtlHi     = 97;
  localparam int unsigned CtlLo     = 96;
  localparam int unsigned AHi       = 95;
  localparam int unsigned ALo       = 64;
  localparam int unsigned BHi       = 63;
  localparam int unsigned BLo       = 32;
  localparam int unsigned ResHi     = 31;
  localparam int unsigned ResLo     = 0;

  // All-ones is never a consistent ALU vector, so it marks the end of the table.
  localparam logic [VecW-1:0] TERMINATOR = {VecW{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StCheck,
    StDone
  } runner_state_t;

endpackage

// File: rtl/alu_vec_compare.sv
// Exact-equality comparison of ALU outputs against expected values.
// Mask bits: [2] result, [1] zero, [0] overflow.
module alu_vec_compare (
  input  logic [31:0] exp_result,
  input  logic        exp_zero,
  input  logic        exp_overflow,
  input  logic [31:0] act_result,
  input  logic        act_zero,
  input  logic        act_overflow,
  output logic [2:0]  mask
);

  always_comb begin
    mask    = 3'b000;
    mask[2] = (act_result != exp_result);
    mask[1] = (act_zero != exp_zero);
    mask[0] = (act_overflow != exp_overflow);
  end

endmodule

// File: rtl/alu_vector_runner.sv
// Fetches ALU test vectors from a synchronous ROM, drives the DUT operands and
// checks its outputs, counting mismatches until a terminator or the end of the ROM.
module alu_vector_runner
  import alu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned DUT_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VecW-1:0]   mem_rdata,
  output logic [31:0]       a,
  output logic [31:0]       b,
  output logic [1:0]        controle,
  input  logic [31:0]       result,
  input  logic              zero,
  input  logic              overflow,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  errors,
  output logic [ADDR_W-1:0] vectornum,
  output logic              err_strobe,
  output logic [2:0]        err_mask
);

  localparam logic [31:0] LastWait = 32'(DUT_LATENCY - 1);

  runner_state_t state_q, state_d;

  logic [31:0] wait_cnt_q;
  logic [31:0] exp_result_q;
  logic        exp_zero_q;
  logic        exp_ovf_q;
  logic        is_term;
  logic [2:0]  mask;

  assign is_term  = (mem_rdata == TERMINATOR);
  assign mem_addr = vectornum;

  alu_vec_compare u_compare (
    .exp_result  (exp_result_q),
    .exp_zero    (exp_zero_q),
    .exp_overflow(exp_ovf_q),
    .act_result  (result),
    .act_zero    (zero),
    .act_overflow(overflow),
    .mask        (mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad:  state_d = is_term ? StDone : StWait;
      StWait:  if (wait_cnt_q == LastWait) state_d = StCheck;
      StCheck: state_d = (vectornum == '1) ? StDone : StFetch;
      StDone:  if (start) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StFetch, StLoad, StWait, StCheck: busy = 1'b1;
      StDone:                           done = 1'b1;
      default:                          ;
    endcase
    pass = done && (errors == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a            <= '0;
      b            <= '0;
      controle     <= '0;
      errors       <= '0;
      vectornum    <= '0;
      err_strobe   <= 1'b0;
      err_mask     <= '0;
      wait_cnt_q   <= '0;
      exp_result_q <= '0;
      exp_zero_q   <= 1'b0;
      exp_ovf_q    <= 1'b0;
    end else begin
      err_strobe <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            errors    <= '0;
            vectornum <= '0;
          end
        end
        StLoad: begin
          wait_cnt_q <= '0;
          if (!is_term) begin
            a            <= mem_rdata[AHi:ALo];
            b            <= mem_rdata[BHi:BLo];
            controle     <= mem_rdata[CtlHi:CtlLo];
            exp_result_q <= mem_rdata[ResHi:ResLo];
            exp_zero_q   <= mem_rdata[ZeroExpB];
            exp_ovf_q    <= mem_rdata[OvfExpB];
          end
        end
        StWait: wait_cnt_q <= wait_cnt_q + 32'd1;
        StCheck: begin
          if (mask != 3'b000) begin
            err_strobe <= 1'b1;
            err_mask   <= mask;
            if (errors != '1) errors <= errors + 1'b1;
          end
          // On the last ROM address the index stays put and the run ends.
          if (vectornum != '1) vectornum <= vectornum + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_runner.sv
// Directed bench: three runner instances (default, ERR_W=2, DUT_LATENCY=3) against
// behavioural ALU models with hand-computed vectors.
module tb_alu_vector_runner;

  localparam logic [99:0] Term = {100{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset1;
  logic start0, start1, start2;

  logic [13:0] addr0, addr1, addr2, vnum0, vnum1, vnum2;
  logic [99:0] rdata0, rdata1, rdata2;
  logic [31:0] a0, b0, a1, b1, a2, b2, res0, res1, res2;
  logic [1:0]  ctl0, ctl1, ctl2;
  logic        z0, o0, z1, o1, z2, o2;
  logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic        stb0, stb1, stb2;
  logic [2:0]  mask0, mask1, mask2;
  logic [15:0] err0, err2;
  logic [1:0]  err1;

  logic [99:0] rom0 [0:16383];
  logic [99:0] rom1 [0:16383];
  logic [99:0] rom2 [0:16383];
  logic [33:0] pipe1, pipe2;

  int checks = 0;
  int failures = 0;
  int nstb0 = 0;
  int nstb1 = 0;
  logic [2:0] last_mask0 = 3'b000;
  logic [2:0] last_mask1 = 3'b000;

  function automatic logic [33:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] c);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (c)
      2'b00: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
      2'b01: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
      2'b10: r = x & y;
      default: r = x | y;
    endcase
    return {(r == 32'd0), v, r};
  endfunction

  function automatic logic [99:0] vec(input logic z, input logic o, input logic [1:0] c,
                                      input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] r);
    return {z, o, c, x, y, r};
  endfunction

  always_comb {z0, o0, res0} = alu_model(a0, b0, ctl0);
  always_comb {z1, o1, res1} = alu_model(a1, b1, ctl1);
  assign {z2, o2, res2} = pipe2;

  always @(posedge clk) begin
    rdata0 <= rom0[addr0];
    rdata1 <= rom1[addr1];
    rdata2 <= rom2[addr2];
    pipe1  <= alu_model(a2, b2, ctl2);
    pipe2  <= pipe1;
  end

  always @(negedge clk) begin
    if (stb0) begin nstb0 <= nstb0 + 1; last_mask0 <= mask0; end
    if (stb1) begin nstb1 <= nstb1 + 1; last_mask1 <= mask1; end
  end

  alu_vector_runner u_run0 (
    .clk(clk), .reset(reset), .start(start0), .mem_addr(addr0), .mem_rdata(rdata0),
    .a(a0), .b(b0), .controle(ctl0), .result(res0), .zero(z0), .overflow(o0),
    .busy(busy0), .done(done0), .pass(pass0), .errors(err0), .vectornum(vnum0),
    .err_strobe(stb0), .err_mask(mask0)
  );

  alu_vector_runner #(.ERR_W(2)) u_run1 (
    .clk(clk), .reset(reset1), .start(start1), .mem_addr(addr1), .mem_rdata(rdata1),
    .a(a1), .b(b1), .controle(ctl1), .result(res1), .zero(z1), .overflow(o1),
    .busy(busy1), .done(done1), .pass(pass1), .errors(err1), .vectornum(vnum1),
    .err_strobe(stb1), .err_mask(mask1)
  );

  alu_vector_runner #(.DUT_LATENCY(3)) u_run2 (
    .clk(clk), .reset(reset), .start(start2), .mem_addr(addr2), .mem_rdata(rdata2),
    .a(a2), .b(b2), .controle(ctl2), .result(res2), .zero(z2), .overflow(o2),
    .busy(busy2), .done(done2), .pass(pass2), .errors(err2), .vectornum(vnum2),
    .err_strobe(stb2), .err_mask(mask2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_done(input int which);
    case (which)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  task automatic pulse_start(input int which);
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the start pulse; returns the cycle done was seen.
  task automatic run_until_done(input int which, input int first, output int cycles);
    cycles = first;
    while (!sel_done(which) && cycles < 300) begin
      tick();
      cycles++;
    end
    if (!sel_done(which)) check("done_timeout", {127'd0, sel_done(which)}, 128'd1);
  endtask

  int cyc;
  int base;

  initial begin
    reset  = 1'b1;
    reset1 = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;

    rom0[0] = vec(1'b0, 1'b0, 2'b00, 32'h5, 32'h3, 32'h8);
    rom0[1] = Term;
    for (int k = 0; k < 5; k++) rom1[k] = vec(1'b0, 1'b0, 2'b00, 32'(k + 1), 32'h1, 32'h0);
    rom1[5] = Term;
    rom2[0] = vec(1'b0, 1'b0, 2'b10, 32'h5, 32'h3, 32'h1);
    rom2[1] = vec(1'b0, 1'b0, 2'b11, 32'h5, 32'h3, 32'h7);
    rom2[2] = Term;

    tick();
    tick();
    reset  = 1'b0;
    reset1 = 1'b0;
    tick();
    check("reset_outputs0", {8'd0, a0, b0, ctl0, addr0, mask0, err0, vnum0,
                             busy0, done0, pass0, stb0}, 128'd0);

    // Single add vector, then terminator
    pulse_start(0);
    check("busy_after_start", {127'd0, busy0}, 128'd1);
    check("first_addr", {114'd0, addr0}, 128'd0);
    run_until_done(0, 1, cyc);
    check("add_done_cycle", 128'(cyc), 128'd7);
    check("add_vectornum", {114'd0, vnum0}, 128'd1);
    check("add_errors", {112'd0, err0}, 128'd0);
    check("add_pass", {126'd0, pass0, busy0}, 128'd2);
    check("add_strobes", 128'(nstb0), 128'd0);
    tick();
    tick();
    check("done_held", {127'd0, done0}, 128'd1);

    // Wrong expectation on 1-1: result and zero mismatch
    rom0[0] = vec(1'b0, 1'b0, 2'b01, 32'h1, 32'h1, 32'h1);
    base = nstb0;
    pulse_start(0);
    check("restart_clears_done", {127'd0, done0}, 128'd0);
    run_until_done(0, 1, cyc);
    check("sub_strobes", 128'(nstb0 - base), 128'd1);
    check("sub_mask", {125'd0, last_mask0}, 128'b110);
    check("sub_errors", {112'd0, err0}, 128'd1);
    check("sub_pass", {127'd0, pass0}, 128'd0);

    // Signed overflow on add and sub; a second start mid-run must be ignored
    rom0[0] = vec(1'b0, 1'b1, 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    rom0[1] = vec(1'b0, 1'b1, 2'b01, 32'h80000000, 32'h1, 32'h7FFFFFFF);
    rom0[2] = Term;
    base = nstb0;
    pulse_start(0);
    check("start_clears_errors", {112'd0, err0}, 128'd0);
    pulse_start(0);
    run_until_done(0, 2, cyc);
    check("ovf_done_cycle", 128'(cyc), 128'd11);
    check("ovf_errors", {112'd0, err0}, 128'd0);
    check("ovf_pass", {127'd0, pass0}, 128'd1);
    check("ovf_vectornum", {114'd0, vnum0}, 128'd2);
    check("ovf_strobes", 128'(nstb0 - base), 128'd0);
    check("operands_held", {62'd0, a0, b0, ctl0}, {62'd0, 32'h80000000, 32'h1, 2'b01});

    // Terminator at address 0
    rom0[0] = Term;
    pulse_start(0);
    tick();
    check("term0_not_early", {127'd0, done0}, 128'd0);
    run_until_done(0, 2, cyc);
    check("term0_done_cycle", 128'(cyc), 128'd3);
    check("term0_vectornum", {114'd0, vnum0}, 128'd0);
    check("term0_errors", {112'd0, err0}, 128'd0);

    // ERR_W=2: reset during WAIT of vector 2, then a full run that saturates
    base = nstb1;
    pulse_start(1);
    for (int i = 0; i < 10; i++) tick();
    check("pre_reset_errors", {126'd0, err1}, 128'd2);
    check("pre_reset_strobes", 128'(nstb1 - base), 128'd2);
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    check("midrun_reset_outputs", {22'd0, a1, b1, ctl1, addr1, mask1, err1, vnum1,
                                   busy1, done1, pass1, stb1}, 128'd0);
    tick();
    check("stays_idle", {126'd0, busy1, done1}, 128'd0);
    base = nstb1;
    pulse_start(1);
    check("rerun_addr0", {114'd0, addr1}, 128'd0);
    run_until_done(1, 1, cyc);
    check("sat_done_cycle", 128'(cyc), 128'd23);
    check("sat_errors", {126'd0, err1}, 128'd3);
    check("sat_strobes", 128'(nstb1 - base), 128'd5);
    check("sat_mask", {125'd0, last_mask1}, 128'b100);
    check("sat_vectornum", {114'd0, vnum1}, 128'd5);
    check("sat_pass", {127'd0, pass1}, 128'd0);

    // DUT_LATENCY=3 against a two-stage pipelined ALU
    pulse_start(2);
    for (int i = 0; i < 5; i++) tick();
    check("lat3_addr_c6", {114'd0, addr2}, 128'd0);
    tick();
    check("lat3_addr_c7", {114'd0, addr2}, 128'd1);
    run_until_done(2, 7, cyc);
    check("lat3_done_cycle", 128'(cyc), 128'd15);
    check("lat3_errors", {112'd0, err2}, 128'd0);
    check("lat3_pass", {127'd0, pass2}, 128'd1);
    check("lat3_no_strobe", {127'd0, stb2}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
